// File: rtl/bp_update_sched.sv
// bp_update_sched: commit-to-predictor update FIFO with post-reset table clear.
// Optional same-cycle bypass of an empty FIFO when BP_UPD_BYPASS_EN is defined.
module bp_update_sched #(
   parameter int COMMIT_WIDTH = 4,
   parameter int DEPTH        = 8,
   parameter int INDEX_BITS   = 7
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [COMMIT_WIDTH-1:0]   ret_valid,
   input  logic [32*COMMIT_WIDTH-1:0] ret_pc,
   input  logic [32*COMMIT_WIDTH-1:0] ret_target,
   input  logic [COMMIT_WIDTH-1:0]   ret_taken,
   input  logic [COMMIT_WIDTH-1:0]   ret_pred_taken,
   output logic                      ret_ready,
   output logic                      mispredict,
   output logic [31:0]               redirect_pc,
   output logic                      upd_valid,
   output logic [31:0]               upd_pc,
   output logic [31:0]               upd_target,
   output logic                      upd_taken,
   input  logic                      upd_ready,
   output logic                      clr_valid,
   output logic [INDEX_BITS-1:0]     clr_index,
   output logic                      init_busy
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
   } rec_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [INDEX_BITS-1:0] r_clr_idx;
   rec_t                  r_mem [DEPTH];
   logic [PW-1:0]         r_rd;
   logic [PW-1:0]         r_wr;
   logic [CNTW-1:0]       r_cnt;

   logic [COMMIT_WIDTH-1:0] w_eff;
   logic [COMMIT_WIDTH-1:0] w_enq;
   logic                    w_mis_found;
   logic [31:0]             w_mis_tgt;
   rec_t                    w_first;
   logic                    w_any;
   logic [PW-1:0]           w_off [COMMIT_WIDTH];
   logic [CNTW-1:0]         w_n_enq;
   logic [CNTW-1:0]         w_space;
   logic                    w_run;
   logic                    w_byp;
   logic                    w_byp_take;
   logic                    w_pop;
   logic                    w_push;
   rec_t                    w_head;

   // Slots younger than the oldest mispredict are dropped.
   always_comb begin
      w_eff       = '0;
      w_mis_found = 1'b0;
      w_mis_tgt   = '0;
      w_first     = '0;
      w_any       = 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (ret_valid[i] && !w_mis_found) begin
            w_eff[i] = 1'b1;
            if (!w_any) begin
               w_first.pc    = ret_pc[i*32 +: 32];
               w_first.tgt   = ret_target[i*32 +: 32];
               w_first.taken = ret_taken[i];
            end
            w_any = 1'b1;
            if (ret_pred_taken[i] != ret_taken[i]) begin
               w_mis_found = 1'b1;
               w_mis_tgt   = ret_target[i*32 +: 32];
            end
         end
      end
   end

   assign w_run = (r_state == S_RUN) && !reset;

`ifdef BP_UPD_BYPASS_EN
   assign w_byp = w_run && (r_cnt == '0) && w_any;
`else
   assign w_byp = 1'b0;
`endif

   assign w_byp_take = w_byp && upd_ready;

   always_comb begin : p_enq
      logic w_drop;
      w_drop  = w_byp_take;
      w_enq   = w_eff;
      w_n_enq = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_off[i] = w_n_enq[PW-1:0];
         if (w_eff[i] && w_drop) begin
            w_enq[i] = 1'b0;
            w_drop   = 1'b0;
         end else if (w_eff[i]) begin
            w_n_enq = w_n_enq + CNTW'(1);
         end
      end
   end

   assign w_pop       = w_run && (r_cnt != '0) && upd_ready;
   assign w_space     = CNTW'(DEPTH) - (r_cnt - CNTW'(w_pop));
   assign ret_ready   = w_run && (w_space >= w_n_enq);
   assign w_push      = ret_ready && (w_n_enq != '0);
   assign mispredict  = ret_ready && w_mis_found;
   assign redirect_pc = mispredict ? w_mis_tgt : '0;

   assign upd_valid  = w_run && ((r_cnt != '0) || w_byp);
   assign w_head     = (r_cnt != '0) ? r_mem[r_rd] : w_first;
   assign upd_pc     = w_head.pc;
   assign upd_target = w_head.tgt;
   assign upd_taken  = w_head.taken;
   assign clr_index  = r_clr_idx;

   always_comb begin
      w_state_nxt = r_state;
      clr_valid   = 1'b0;
      init_busy   = 1'b1;
      unique case (r_state)
         S_CLEAR: begin
            clr_valid = !reset;
            if (r_clr_idx == '1)
               w_state_nxt = S_RUN;
         end
         S_RUN: init_busy = reset;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_CLEAR;
         r_clr_idx <= '0;
         r_rd      <= '0;
         r_wr      <= '0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR)
            r_clr_idx <= r_clr_idx + INDEX_BITS'(1);
         if (w_pop)
            r_rd <= r_rd + PW'(1);
         if (w_push)
            r_wr <= r_wr + w_n_enq[PW-1:0];
         r_cnt <= r_cnt + (w_push ? w_n_enq : '0) - CNTW'(w_pop);
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (w_push && w_enq[i]) begin
            r_mem[r_wr + w_off[i]] <= '{
               pc:    ret_pc[i*32 +: 32],
               tgt:   ret_target[i*32 +: 32],
               taken: ret_taken[i]
            };
         end
      end
   end

endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: randomized and directed checks of bp_update_sched
// against a queue-based reference model.
module tb_bp_update_sched;

   localparam int CW   = 4;
   localparam int DEP  = 8;
   localparam int IB   = 7;
   localparam int NIDX = 1 << IB;

   logic            clock;
   logic            reset;
   logic [CW-1:0]   ret_valid;
   logic [32*CW-1:0] ret_pc;
   logic [32*CW-1:0] ret_target;
   logic [CW-1:0]   ret_taken;
   logic [CW-1:0]   ret_pred_taken;
   logic            ret_ready;
   logic            mispredict;
   logic [31:0]     redirect_pc;
   logic            upd_valid;
   logic [31:0]     upd_pc;
   logic [31:0]     upd_target;
   logic            upd_taken;
   logic            upd_ready;
   logic            clr_valid;
   logic [IB-1:0]   clr_index;
   logic            init_busy;

   bp_update_sched #(
      .COMMIT_WIDTH(CW), .DEPTH(DEP), .INDEX_BITS(IB)
   ) dut (
      .clock(clock), .reset(reset),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_target(ret_target),
      .ret_taken(ret_taken), .ret_pred_taken(ret_pred_taken),
      .ret_ready(ret_ready), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .upd_ready(upd_ready), .clr_valid(clr_valid),
      .clr_index(clr_index), .init_busy(init_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

`ifdef BP_UPD_BYPASS_EN
   bit byp_en = 1'b1;
`else
   bit byp_en = 1'b0;
`endif

   logic [64:0] m_q[$];
   int          m_clr = 0;
   bit          m_last_rdy = 1'b0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: compare outputs against the model, then advance the model.
   task automatic cyc();
      int          eff[$];
      bit          found;
      int          m;
      int          cnt;
      int          need;
      bit          run;
      bit          pop;
      bit          byp;
      bit          take;
      bit          rdy;
      bit          uv;
      logic [64:0] head;
      logic [64:0] rec;
      #1;
      if (reset) begin
         chk("rst_ret_ready", 64'(ret_ready), 64'(0));
         chk("rst_upd_valid", 64'(upd_valid), 64'(0));
         chk("rst_mispredict", 64'(mispredict), 64'(0));
         chk("rst_redirect", 64'(redirect_pc), 64'(0));
         chk("rst_clr_valid", 64'(clr_valid), 64'(0));
         chk("rst_init_busy", 64'(init_busy), 64'(1));
         m_q.delete();
         m_clr = 0;
         m_last_rdy = 1'b0;
      end else begin
         run = (m_clr >= NIDX);
         found = 1'b0;
         m = 0;
         for (int i = 0; i < CW; i++) begin
            if (!found && ret_valid[i]) begin
               eff.push_back(i);
               if (ret_taken[i] != ret_pred_taken[i]) begin
                  found = 1'b1;
                  m = i;
               end
            end
         end
         cnt  = m_q.size();
         pop  = run && cnt > 0 && upd_ready;
         byp  = byp_en && run && cnt == 0 && eff.size() > 0;
         take = byp && upd_ready;
         need = eff.size() - (take ? 1 : 0);
         rdy  = run && (DEP - (cnt - (pop ? 1 : 0))) >= need;
         uv   = run && (cnt > 0 || byp);
         chk("clr_valid", 64'(clr_valid), 64'(!run));
         chk("init_busy", 64'(init_busy), 64'(!run));
         if (!run)
            chk("clr_index", 64'(clr_index), 64'(m_clr));
         chk("ret_ready", 64'(ret_ready), 64'(rdy));
         chk("mispredict", 64'(mispredict), 64'(rdy && found));
         chk("redirect_pc", 64'(redirect_pc),
             (rdy && found) ? 64'(ret_target[m*32 +: 32]) : 64'(0));
         chk("upd_valid", 64'(upd_valid), 64'(uv));
         if (uv) begin
            if (cnt > 0)
               head = m_q[0];
            else
               head = {ret_pc[eff[0]*32 +: 32], ret_target[eff[0]*32 +: 32],
                       ret_taken[eff[0]]};
            chk("upd_pc", 64'(upd_pc), 64'(head[64:33]));
            chk("upd_target", 64'(upd_target), 64'(head[32:1]));
            chk("upd_taken", 64'(upd_taken), 64'(head[0]));
         end
         if (pop)
            void'(m_q.pop_front());
         if (rdy) begin
            for (int k = (take ? 1 : 0); k < eff.size(); k++) begin
               rec = {ret_pc[eff[k]*32 +: 32], ret_target[eff[k]*32 +: 32],
                      ret_taken[eff[k]]};
               m_q.push_back(rec);
            end
         end
         if (m_clr < NIDX)
            m_clr++;
         m_last_rdy = rdy;
      end
      @(negedge clock);
   endtask

   task automatic set_grp(logic [CW-1:0] v, logic [CW-1:0] pt,
                          logic [CW-1:0] tk, logic [31:0] base);
      ret_valid = v;
      ret_pred_taken = pt;
      ret_taken = tk;
      for (int i = 0; i < CW; i++) begin
         ret_pc[i*32 +: 32] = base + 32'(4 * i);
         ret_target[i*32 +: 32] = base + 32'h1000 + 32'(4 * i);
      end
   endtask

   task automatic rand_grp();
      logic [CW-1:0] pt;
      logic [CW-1:0] flip;
      if (m_last_rdy || ret_valid == '0) begin
         pt = CW'($urandom);
         flip = '0;
         for (int i = 0; i < CW; i++)
            flip[i] = ($urandom_range(0, 7) == 0);
         ret_valid = CW'($urandom);
         ret_pred_taken = pt;
         ret_taken = pt ^ flip;
         for (int i = 0; i < CW; i++) begin
            ret_pc[i*32 +: 32] = $urandom;
            ret_target[i*32 +: 32] = $urandom;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      upd_ready = 1'b0;
      set_grp('0, '0, '0, 32'h0);
      @(negedge clock);
      repeat (3) cyc();
      reset = 1'b0;
      // clear walk with idle commit
      repeat (NIDX + 4) begin
         upd_ready = 1'($urandom);
         cyc();
      end
      upd_ready = 1'b1;
      set_grp(4'b1011, 4'b0000, 4'b0000, 32'h100);
      cyc();
      set_grp('0, '0, '0, 32'h0);
      repeat (4) cyc();
      set_grp(4'b1111, 4'b0010, 4'b0000, 32'h0);
      cyc();
      set_grp('0, '0, '0, 32'h0);
      repeat (4) cyc();
      // fill with the predictor stalled, then pop-and-push when full
      upd_ready = 1'b0;
      set_grp(4'b1111, '0, '0, 32'h200);
      cyc();
      set_grp(4'b1111, '0, '0, 32'h300);
      cyc();
      set_grp(4'b1111, '0, '0, 32'h400);
      repeat (2) cyc();
      upd_ready = 1'b1;
      set_grp(4'b0001, '0, '0, 32'h500);
      cyc();
      set_grp('0, '0, '0, 32'h0);
      upd_ready = 1'b0;
      cyc();
      upd_ready = 1'b1;
      repeat (10) cyc();
      // random traffic
      repeat (2000) begin
         upd_ready = ($urandom_range(0, 3) != 0);
         rand_grp();
         cyc();
      end
      // reset mid-RUN with a loaded FIFO, then reset again mid-walk
      upd_ready = 1'b0;
      repeat (6) begin
         rand_grp();
         cyc();
      end
      set_grp('0, '0, '0, 32'h0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (50) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (NIDX + 2) begin
         upd_ready = 1'($urandom);
         cyc();
      end
      repeat (500) begin
         upd_ready = ($urandom_range(0, 1) != 0);
         rand_grp();
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
